hall_sector_decoder: RTL and testbench
======================================

Name: hall_sector_decoder

Overview:
- Consumes three debounced Hall sensor levels and their per-bit change strobes, one debounce instance per sensor.
- Produces the electrical sector (0..5), rotation direction and a one-cycle commutate pulse per valid step.
- Measures the clock-cycle interval between consecutive valid steps, flags stall and sticky invalid-sequence faults.
- Feeds the commutation and speed-control stages.

Parameters:
- period_sz, 24, width of the step-interval counter and period output; counter saturation at all-ones defines the stall timeout (2^24-1 cycles ≈ 0.31 s at 54 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- hall  input  3  debounced Hall levels {C,B,A}
- hall_change  input  3  per-bit one-cycle change strobes; new level on hall is valid the cycle after the strobe
- fault_clr  input  1  one-cycle pulse, clears fault
- sector  output  3  current sector 0..5; 7 = unknown/invalid
- sector_valid  output  1  sector holds a valid code
- direction  output  1  1 = forward (sector increasing mod 6), 0 = reverse
- dir_valid  output  1  direction is trustworthy
- commutate  output  1  one-cycle pulse per valid adjacent step
- period  output  period_sz  clk cycles between the last two valid steps
- period_valid  output  1  period is a true step-to-step measurement
- stalled  output  1  no valid step within the timeout
- fault  output  1  sticky: invalid code or non-adjacent jump seen

Behaviour:
- Code map {C,B,A}: 001→0, 011→1, 010→2, 110→3, 100→4, 101→5. Codes 000 and 111 are invalid.
- Reset values: sector=7, sector_valid=0, direction=0, dir_valid=0, commutate=0, period=0, period_valid=0, stalled=0, fault=0. State=ACQUIRE, cnt=0, no stored sector.
- Evaluate strobe: eval = registered OR of hall_change. The code on hall is decoded in the cycle where eval=1. Outputs update on the following edge, so a hall_change pulse at cycle t yields updated outputs at t+2.
- Interval counter cnt:
  - Each cycle without a step: cnt <= sat(cnt+1).
  - On a step cycle: period <= sat(cnt+1) and cnt <= 0.
  - Steps N cycles apart therefore give period = N.
- States and transitions:
  - ACQUIRE: a valid code latches sector and sets sector_valid=1, with no commutate. With a sector already known, an adjacent step pulses commutate, sets direction and dir_valid=1, and moves to LOCKED. period_valid stays 0.
  - LOCKED: an adjacent step in the same direction pulses commutate, sets period_valid=1 and moves to RUN.
  - RUN: each same-direction adjacent step pulses commutate and updates period.
  - Direction reversal (adjacent step opposite to direction) in LOCKED or RUN: commutate pulses, direction flips, period_valid=0, state becomes LOCKED.
  - Invalid code (000/111): sector=7, sector_valid=0, dir_valid=0, period_valid=0, fault=1, state becomes ACQUIRE with no stored sector.
  - Non-adjacent valid code (skip, or multi-bit change): sector latched, dir_valid=0, period_valid=0, fault=1, state becomes ACQUIRE with that sector stored. No commutate.
  - eval with unchanged code: no action.
- Stall: when cnt reaches all-ones in LOCKED or RUN, stalled=1, dir_valid=0, period_valid=0 and state becomes ACQUIRE. sector is retained. stalled clears on the next commutate. The period captured on that step is the saturated value and period_valid stays 0.
- fault_clr clears fault. If fault_clr coincides with a new fault event, fault stays 1.
- rst mid-rotation: all state returns to reset values on the next edge. The first step after reset never produces period_valid.

Optional Feature:
- Macro HALL_SECTOR_OFFSET_EN.
- With the macro: an added input port sector_offset (3 bits) is added mod 6 to the decoded sector before the sector output register. Offset values 6 and 7 are treated as 0. Direction, fault and step logic always operate on the raw sector. An invalid code still outputs 7.
- Without the macro: the port is absent and sector is the raw decoded value.

Test Plan:
- Reset, hall=001 with strobe → sector=0, sector_valid=1, commutate=0, dir_valid=0. Then 011 after 100 cycles → commutate pulse, sector=1, direction=1, dir_valid=1, period_valid=0.
- Forward sequence 001,011,010,110 with steps every 1000 cycles → period=1000, period_valid=1 from the third step, one commutate per step.
- In RUN forward at sector 3 (hall=110), step back to 010 → sector=2, direction=0, commutate pulse, period_valid=0. A further reverse step 011 → period_valid=1.
- hall=111 → sector=7, sector_valid=0, fault=1. Then 001→011 → reacquire, fault still 1 until a fault_clr pulse. fault_clr coincident with an invalid code → fault remains 1.
- Jump 001→010 (skip) → fault=1, no commutate, sector=2, dir_valid=0.
- period_sz=8: hold hall static after LOCKED → stalled=1 exactly when cnt=255, period_valid=0. The next adjacent step clears stalled and reports period=255.

Source files
------------

// File: rtl/hall_sector_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hall_sector_decoder
// Brief    : Hall code -> electrical sector, direction, commutate pulse,
//            step period, stall and sticky fault. Optional HALL_SECTOR_OFFSET_EN
//            adds a sector_offset input applied to the sector output only.
// Revision : 1.0
// ============================================================================
module hall_sector_decoder #(
    parameter int PERIOD_SZ = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           hall,
    input  logic [2:0]           hall_change,
    input  logic                 fault_clr,
`ifdef HALL_SECTOR_OFFSET_EN
    input  logic [2:0]           sector_offset,
`endif
    output logic [2:0]           sector,
    output logic                 sector_valid,
    output logic                 direction,
    output logic                 dir_valid,
    output logic                 commutate,
    output logic [PERIOD_SZ-1:0] period,
    output logic                 period_valid,
    output logic                 stalled,
    output logic                 fault
);

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam logic [PERIOD_SZ-1:0] C_CNT_MAX = '1;
    localparam logic [PERIOD_SZ-1:0] C_CNT_ONE = {{(PERIOD_SZ-1){1'b0}}, 1'b1};
    localparam logic [2:0]           C_NONE    = 3'd7;

    state_t                 r_state, w_state_nxt;
    logic                   r_eval;
    logic [2:0]             r_raw, w_raw_nxt;
    logic [2:0]             r_sector, w_sector_nxt;
    logic                   r_sector_valid, w_sector_valid_nxt;
    logic                   r_direction, w_direction_nxt;
    logic                   r_dir_valid, w_dir_valid_nxt;
    logic                   r_commutate, w_commutate_nxt;
    logic [PERIOD_SZ-1:0]   r_period, w_period_nxt;
    logic                   r_period_valid, w_period_valid_nxt;
    logic                   r_stalled, w_stalled_nxt;
    logic                   r_fault, w_fault_evt;
    logic [PERIOD_SZ-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;

    logic [2:0]             w_code, w_sector_out, w_fwd_pos, w_rev_pos;
    logic                   w_code_ok, w_known, w_is_fwd, w_is_rev, w_step;

    always_comb begin
        w_code    = C_NONE;
        w_code_ok = 1'b1;
        case (hall)
            3'b001:  w_code = 3'd0;
            3'b011:  w_code = 3'd1;
            3'b010:  w_code = 3'd2;
            3'b110:  w_code = 3'd3;
            3'b100:  w_code = 3'd4;
            3'b101:  w_code = 3'd5;
            default: w_code_ok = 1'b0;
        endcase
    end

    assign w_known   = (r_raw != C_NONE);
    assign w_fwd_pos = (r_raw == 3'd5) ? 3'd0 : r_raw + 3'd1;
    assign w_rev_pos = (r_raw == 3'd0) ? 3'd5 : r_raw - 3'd1;
    assign w_is_fwd  = w_known && w_code_ok && (w_code == w_fwd_pos);
    assign w_is_rev  = w_known && w_code_ok && (w_code == w_rev_pos);
    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + C_CNT_ONE;

`ifdef HALL_SECTOR_OFFSET_EN
    // Offset only rotates the reported sector; stepping logic stays on raw codes
    logic [2:0] w_offset;
    logic [3:0] w_sum, w_sum_m6;
    assign w_offset     = (sector_offset > 3'd5) ? 3'd0 : sector_offset;
    assign w_sum        = {1'b0, w_code} + {1'b0, w_offset};
    assign w_sum_m6     = w_sum - 4'd6;
    assign w_sector_out = (w_sum >= 4'd6) ? w_sum_m6[2:0] : w_sum[2:0];
`else
    assign w_sector_out = w_code;
`endif

    always_comb begin
        w_state_nxt        = r_state;
        w_raw_nxt          = r_raw;
        w_sector_nxt       = r_sector;
        w_sector_valid_nxt = r_sector_valid;
        w_direction_nxt    = r_direction;
        w_dir_valid_nxt    = r_dir_valid;
        w_period_nxt       = r_period;
        w_period_valid_nxt = r_period_valid;
        w_stalled_nxt      = r_stalled;
        w_commutate_nxt    = 1'b0;
        w_fault_evt        = 1'b0;
        w_step             = 1'b0;
        w_cnt_nxt          = w_cnt_inc;

        if (r_eval) begin
            if (!w_code_ok) begin
                w_sector_nxt       = C_NONE;
                w_sector_valid_nxt = 1'b0;
                w_dir_valid_nxt    = 1'b0;
                w_period_valid_nxt = 1'b0;
                w_raw_nxt          = C_NONE;
                w_fault_evt        = 1'b1;
                w_state_nxt        = ST_ACQUIRE;
            end else if (w_code != r_raw) begin
                w_raw_nxt          = w_code;
                w_sector_nxt       = w_sector_out;
                w_sector_valid_nxt = 1'b1;
                if (w_is_fwd || w_is_rev) begin
                    w_step          = 1'b1;
                    w_commutate_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_period_nxt    = w_cnt_inc;
                    w_stalled_nxt   = 1'b0;
                    w_direction_nxt = w_is_fwd;
                    w_dir_valid_nxt = 1'b1;
                    // Only a second same-direction step while tracking yields a true period
                    if (r_state == ST_ACQUIRE || w_is_fwd != r_direction) begin
                        w_state_nxt        = ST_LOCKED;
                        w_period_valid_nxt = 1'b0;
                    end else begin
                        w_state_nxt        = ST_RUN;
                        w_period_valid_nxt = 1'b1;
                    end
                end else if (w_known) begin
                    w_dir_valid_nxt    = 1'b0;
                    w_period_valid_nxt = 1'b0;
                    w_fault_evt        = 1'b1;
                    w_state_nxt        = ST_ACQUIRE;
                end
            end
        end

        // Stall fires in the same edge that the counter lands on all-ones
        if (!w_step && (r_state != ST_ACQUIRE) && (w_cnt_inc == C_CNT_MAX)) begin
            w_stalled_nxt      = 1'b1;
            w_dir_valid_nxt    = 1'b0;
            w_period_valid_nxt = 1'b0;
            w_state_nxt        = ST_ACQUIRE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_ACQUIRE;
            r_eval         <= 1'b0;
            r_raw          <= C_NONE;
            r_sector       <= C_NONE;
            r_sector_valid <= 1'b0;
            r_direction    <= 1'b0;
            r_dir_valid    <= 1'b0;
            r_commutate    <= 1'b0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b0;
            r_fault        <= 1'b0;
            r_cnt          <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_eval         <= |hall_change;
            r_raw          <= w_raw_nxt;
            r_sector       <= w_sector_nxt;
            r_sector_valid <= w_sector_valid_nxt;
            r_direction    <= w_direction_nxt;
            r_dir_valid    <= w_dir_valid_nxt;
            r_commutate    <= w_commutate_nxt;
            r_period       <= w_period_nxt;
            r_period_valid <= w_period_valid_nxt;
            r_stalled      <= w_stalled_nxt;
            r_fault        <= w_fault_evt | (r_fault & ~fault_clr);
            r_cnt          <= w_cnt_nxt;
        end
    end

    assign sector       = r_sector;
    assign sector_valid = r_sector_valid;
    assign direction    = r_direction;
    assign dir_valid    = r_dir_valid;
    assign commutate    = r_commutate;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign stalled      = r_stalled;
    assign fault        = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_hall_sector_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hall_sector_decoder
// Brief    : Scoreboard bench: driver predicts outputs from a sector-level
//            model, monitor pops and compares when each response is due.
// Revision : 1.0
// ============================================================================
module tb_hall_sector_decoder;

    localparam int PSZ = 11;
    localparam int MAX = (1 << PSZ) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [2:0]     hall = 3'b000;
    logic [2:0]     hall_change = 3'b000;
    logic           fault_clr = 1'b0;
    logic [2:0]     sector;
    logic           sector_valid, direction, dir_valid, commutate;
    logic [PSZ-1:0] period;
    logic           period_valid, stalled, fault;
`ifdef HALL_SECTOR_OFFSET_EN
    logic [2:0]     sector_offset = 3'd0;
`endif

    always #5 clk = ~clk;

    hall_sector_decoder #(.PERIOD_SZ(PSZ)) dut (
        .clk          (clk),
        .rst          (rst),
        .hall         (hall),
        .hall_change  (hall_change),
        .fault_clr    (fault_clr),
`ifdef HALL_SECTOR_OFFSET_EN
        .sector_offset(sector_offset),
`endif
        .sector       (sector),
        .sector_valid (sector_valid),
        .direction    (direction),
        .dir_valid    (dir_valid),
        .commutate    (commutate),
        .period       (period),
        .period_valid (period_valid),
        .stalled      (stalled),
        .fault        (fault)
    );

    typedef struct {
        int             due;
        logic [2:0]     sector;
        logic           sv, dir, dv, com;
        logic [PSZ-1:0] period;
        logic           pv, st, flt;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 0;
    int   g_last_s = 0;

    logic [2:0] codes [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    // Reference model state, kept in sector positions and cycle numbers
    bit m_known, m_sv, m_dir, m_dv, m_pv, m_stalled, m_fault;
    int m_pos, m_sector, m_period, m_last, offs;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pos_of(logic [2:0] c);
        for (int i = 0; i < 6; i++) if (codes[i] == c) return i;
        return -1;
    endfunction

    task automatic push_exp(input int due, input bit com);
        exp_t x;
        x.due = due; x.sector = 3'(m_sector); x.sv = m_sv; x.dir = m_dir; x.dv = m_dv;
        x.com = com; x.period = PSZ'(m_period); x.pv = m_pv; x.st = m_stalled; x.flt = m_fault;
        q.push_back(x);
    endtask

    task automatic check_stall(input int upto);
        if (m_dv && (m_last + MAX) < upto) begin
            m_stalled = 1; m_dv = 0; m_pv = 0;
            push_exp(m_last + MAX + 1, 0);
        end
    endtask

    task automatic model_event(input int s, input logic [2:0] code, input bit clr);
        int p;
        bit was_dv, is_step, evt, d;
        check_stall(s);
        was_dv = m_dv; is_step = 0; evt = 0;
        p = pos_of(code);
        if (p < 0) begin
            m_known = 0; m_sector = 7; m_sv = 0; m_dv = 0; m_pv = 0; evt = 1;
        end else if (m_known && p == m_pos) begin
            is_step = 0;
        end else if (m_known && (p == (m_pos + 1) % 6 || p == (m_pos + 5) % 6)) begin
            d = (p == (m_pos + 1) % 6);
            is_step = 1;
            m_pv = m_dv && (d == m_dir);
            m_dir = d; m_dv = 1;
            m_period = ((s - m_last) > MAX) ? MAX : (s - m_last);
            m_last = s; m_stalled = 0;
            m_pos = p; m_sector = (p + offs) % 6; m_sv = 1;
        end else if (!m_known) begin
            m_known = 1; m_pos = p; m_sector = (p + offs) % 6; m_sv = 1;
        end else begin
            m_pos = p; m_sector = (p + offs) % 6; m_sv = 1; m_dv = 0; m_pv = 0; evt = 1;
        end
        if (!is_step && was_dv && (m_last + MAX) == s) begin
            m_stalled = 1; m_dv = 0; m_pv = 0;
        end
        m_fault = evt | (m_fault & !clr);
        push_exp(s + 1, is_step);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                tests++; fails++;
                $display("FAIL missed_response: due %0d now %0d", q[0].due, cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("sector",       32'(sector),       32'(e.sector));
                chk("sector_valid", 32'(sector_valid), 32'(e.sv));
                chk("direction",    32'(direction),    32'(e.dir));
                chk("dir_valid",    32'(dir_valid),    32'(e.dv));
                chk("commutate",    32'(commutate),    32'(e.com));
                chk("period",       32'(period),       32'(e.period));
                chk("period_valid", 32'(period_valid), 32'(e.pv));
                chk("stalled",      32'(stalled),      32'(e.st));
                chk("fault",        32'(fault),        32'(e.flt));
            end else begin
                chk("idle_commutate", 32'(commutate), 32'd0);
            end
        end
    end

    task automatic do_reset();
        int g = 0;
        while (q.size() > 0 && g < 5000) begin
            @(posedge clk); #1; check_stall(cyc); g++;
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        m_known = 0; m_sv = 0; m_dir = 0; m_dv = 0; m_pv = 0; m_stalled = 0; m_fault = 0;
        m_pos = 0; m_sector = 7; m_period = 0; m_last = cyc - 1;
        push_exp(cyc, 0);
        mon_en = 1;
    endtask

    task automatic ev(input logic [2:0] code, input bit clr);
        check_stall(cyc);
        hall_change = hall ^ code;
        if (hall_change == 3'b000) hall_change = 3'b001;
        hall = code;
        @(posedge clk); #1;
        hall_change = 3'b000;
        fault_clr = clr;
        g_last_s = cyc;
        model_event(cyc, code, clr);
        @(posedge clk); #1;
        fault_clr = 0;
    endtask

    task automatic ev_at(input int s_target, input logic [2:0] code, input bit clr);
        while (cyc < s_target - 1) begin
            @(posedge clk); #1; check_stall(cyc);
        end
        ev(code, clr);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1; check_stall(cyc);
        end
    endtask

    task automatic clear_fault();
        check_stall(cyc + 1);
        fault_clr = 1;
        m_fault = 0;
        if (q.size() > 0 && q[q.size()-1].due == cyc + 1) q[q.size()-1].flt = 0;
        else push_exp(cyc + 1, 0);
        @(posedge clk); #1;
        fault_clr = 0;
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        offs = 0;
`ifdef HALL_SECTOR_OFFSET_EN
        sector_offset = 3'($urandom_range(0, 7));
        offs = (sector_offset > 3'd5) ? 0 : int'(sector_offset);
`endif
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Acquire, first step, then forward run with 1000-cycle steps
        ev(3'b001, 0);
        ev_at(g_last_s + 100,  3'b011, 0);
        ev_at(g_last_s + 1000, 3'b010, 0);
        ev_at(g_last_s + 1000, 3'b110, 0);
        ev_at(g_last_s + 1000, 3'b010, 0);
        ev_at(g_last_s + 500,  3'b011, 0);

        // Invalid code, reacquire, fault clearing and coincident clear
        ev(3'b111, 0);
        ev(3'b001, 0);
        ev(3'b011, 0);
        clear_fault();
        ev(3'b111, 1);
        clear_fault();

        // Skip jump, then stall and recovery at saturated period
        ev(3'b001, 0);
        ev(3'b010, 0);
        ev(3'b011, 0);
        idle(MAX + 20);
        ev(3'b001, 0);

        // Reset mid-rotation
        ev(3'b101, 0);
        ev(3'b100, 0);
        ev(3'b110, 0);
        do_reset();
        ev(3'b110, 0);
        ev(3'b010, 0);
        ev(3'b011, 0);

        for (int i = 0; i < 300; i++) begin
            int r, cp, gap;
            logic [2:0] code;
            bit clr;
            cp = pos_of(hall);
            r  = $urandom_range(0, 99);
            if (cp < 0 || r < 6)  code = 3'($urandom_range(0, 7));
            else if (r < 55)      code = codes[(cp + 1) % 6];
            else if (r < 78)      code = codes[(cp + 5) % 6];
            else if (r < 86)      code = hall;
            else if (r < 93)      code = codes[(cp + 2 + $urandom_range(0, 2)) % 6];
            else                  code = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
            clr = ($urandom_range(0, 9) == 0);
            gap = ($urandom_range(0, 59) == 0) ? MAX - 3 + $urandom_range(0, 6) : $urandom_range(2, 40);
            if ($urandom_range(0, 99) == 0) do_reset();
            ev_at(g_last_s + gap, code, clr);
            if ($urandom_range(0, 19) == 0) clear_fault();
        end

        g = 0;
        while (q.size() > 0 && g < 5000) begin
            @(posedge clk); #1; check_stall(cyc); g++;
        end
        if (q.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d responses never observed, expected 0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
